// File: rtl/turbo_codec_scheduler.sv
// Purpose: round-robin share of one turbo codec between an encode and a decode job queue.
// Latency: encode BLOCK_LEN+1+codec latency, decode 2+codec latency, accept to rsp_valid.
// Backpressure: one job in flight; req_ready only in IDLE; response held until rsp_ready.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   enc_req_valid/_data/_ready      encode job handshake (data bit 0 goes out first)
//   dec_req_valid/_sym/_ready       decode job handshake ({parity2, parity1, systematic})
//   codec_start/_mode/_data/_sym    serial drive into the codec
//   codec_valid/_enc/_dec           codec result strobe and payload
//   rsp_valid/_src/_data/_timeout   response (src 0 = encode, 1 = decode), rsp_ready accepts
//   busy                            FSM is not in IDLE
module turbo_codec_scheduler #(
    parameter int BLOCK_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_req_valid,
    input  logic [BLOCK_LEN-1:0] enc_req_data,
    output logic                 enc_req_ready,
    input  logic                 dec_req_valid,
    input  logic [2:0]           dec_req_sym,
    output logic                 dec_req_ready,
    output logic                 codec_start,
    output logic                 codec_mode,
    output logic                 codec_data,
    output logic [2:0]           codec_sym,
    input  logic                 codec_valid,
    input  logic [2:0]           codec_enc,
    input  logic                 codec_dec,
    output logic                 rsp_valid,
    output logic                 rsp_src,
    output logic [2:0]           rsp_data,
    output logic                 rsp_timeout,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ENC_FEED  = 3'd1;
    localparam logic [2:0] DEC_ISSUE = 3'd2;
    localparam logic [2:0] WAIT      = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]           state;
    logic                 last_grant;   // 0 = encode won last, 1 = decode won last
    logic [BLOCK_LEN-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [TMR_W-1:0]     timer;
    logic [2:0]           sym_q;
    logic                 grant_enc;
    logic                 grant_dec;

    // On a tie the side that did not win last time gets the codec.
    assign grant_enc = enc_req_valid && (!dec_req_valid || last_grant);
    assign grant_dec = dec_req_valid && (!enc_req_valid || !last_grant);

    // Gated by rst_n so every output reads 0 while reset is held, even with requests pending.
    assign enc_req_ready = rst_n && (state == IDLE) && grant_enc;
    assign dec_req_ready = rst_n && (state == IDLE) && grant_dec;

    assign codec_start = (state == ENC_FEED) || (state == DEC_ISSUE);
    assign codec_data  = (state == ENC_FEED) && shreg[0];
    assign codec_sym   = (state == DEC_ISSUE) ? sym_q : 3'b000;
    assign rsp_valid   = (state == RESP);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            sym_q       <= 3'b000;
            codec_mode  <= 1'b0;
            rsp_src     <= 1'b0;
            rsp_data    <= 3'b000;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_req_valid && enc_req_ready) begin
                        shreg      <= enc_req_data;
                        bit_cnt    <= '0;
                        codec_mode <= 1'b1;
                        rsp_src    <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= ENC_FEED;
                    end else if (dec_req_valid && dec_req_ready) begin
                        sym_q      <= dec_req_sym;
                        codec_mode <= 1'b0;
                        rsp_src    <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= DEC_ISSUE;
                    end
                end
                ENC_FEED: begin
                    shreg   <= {1'b0, shreg[BLOCK_LEN-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BLOCK_LEN - 1)) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                DEC_ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result on the expiry cycle still counts as a result.
                    if (codec_valid) begin
                        rsp_data    <= codec_mode ? codec_enc : {2'b00, codec_dec};
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        rsp_data    <= 3'b000;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_codec_scheduler.sv
module tb_turbo_codec_scheduler;

    localparam int BLOCK_LEN = 8;
    localparam int TIMEOUT   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enc_req_valid;
    logic [BLOCK_LEN-1:0] enc_req_data;
    logic                 enc_req_ready;
    logic                 dec_req_valid;
    logic [2:0]           dec_req_sym;
    logic                 dec_req_ready;
    logic                 codec_start;
    logic                 codec_mode;
    logic                 codec_data;
    logic [2:0]           codec_sym;
    logic                 codec_valid;
    logic [2:0]           codec_enc;
    logic                 codec_dec;
    logic                 rsp_valid;
    logic                 rsp_src;
    logic [2:0]           rsp_data;
    logic                 rsp_timeout;
    logic                 rsp_ready;
    logic                 busy;

    turbo_codec_scheduler #(.BLOCK_LEN(BLOCK_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enc_req_valid (enc_req_valid),
        .enc_req_data  (enc_req_data),
        .enc_req_ready (enc_req_ready),
        .dec_req_valid (dec_req_valid),
        .dec_req_sym   (dec_req_sym),
        .dec_req_ready (dec_req_ready),
        .codec_start   (codec_start),
        .codec_mode    (codec_mode),
        .codec_data    (codec_data),
        .codec_sym     (codec_sym),
        .codec_valid   (codec_valid),
        .codec_enc     (codec_enc),
        .codec_dec     (codec_dec),
        .rsp_valid     (rsp_valid),
        .rsp_src       (rsp_src),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .rsp_ready     (rsp_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of the decode-only job: inputs applied at negedge, outputs compared 1 ns later.
    typedef struct {
        logic       dec_v;
        logic [2:0] dec_sym;
        logic       cv;
        logic       cdec;
        logic       rr;
        logic       e_dec_rdy;
        logic       e_start;
        logic       e_mode;
        logic [2:0] e_sym;
        logic       e_busy;
        logic       e_rv;
        logic       e_src;
        logic [2:0] e_data;
        logic       e_to;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic dv, input logic [2:0] ds, input logic cv,
                                input logic cd, input logic rr, input logic rdy,
                                input logic st, input logic md, input logic [2:0] sy,
                                input logic bz, input logic rv, input logic sr,
                                input logic [2:0] dt, input logic to);
        vec_t v;
        v.dec_v = dv; v.dec_sym = ds; v.cv = cv; v.cdec = cd; v.rr = rr;
        v.e_dec_rdy = rdy; v.e_start = st; v.e_mode = md; v.e_sym = sy;
        v.e_busy = bz; v.e_rv = rv; v.e_src = sr; v.e_data = dt; v.e_to = to;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".enc_ready"}, enc_req_ready, 0);
        chk({tag, ".dec_ready"}, dec_req_ready, 0);
        chk({tag, ".codec_start"}, codec_start, 0);
        chk({tag, ".codec_mode"}, codec_mode, 0);
        chk({tag, ".codec_data"}, codec_data, 0);
        chk({tag, ".codec_sym"}, codec_sym, 0);
        chk({tag, ".rsp_valid"}, rsp_valid, 0);
        chk({tag, ".rsp_src"}, rsp_src, 0);
        chk({tag, ".rsp_data"}, rsp_data, 0);
        chk({tag, ".rsp_timeout"}, rsp_timeout, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    // Reset is released 2 ns after a rising edge so the next negedge sees IDLE.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero(tag);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int exp_bits[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    int k;
    int side;
    int got;
    int rv_seen;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        enc_req_valid = 0; enc_req_data = '0;
        dec_req_valid = 0; dec_req_sym = 3'b000;
        codec_valid = 0; codec_enc = 3'b000; codec_dec = 0;
        rsp_ready = 0;

        // Decode-only table: issue, spurious strobe in DEC_ISSUE, result 6 cycles after issue,
        // one cycle of backpressure, then a spurious strobe while idle.
        tbl[0]  = mk(1, 3'b011, 0, 0, 0,  1, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0);
        tbl[1]  = mk(0, 3'b011, 1, 0, 0,  0, 1, 0, 3'b011, 1, 0, 0, 3'b000, 0);
        tbl[2]  = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0);
        tbl[3]  = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0);
        tbl[4]  = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0);
        tbl[5]  = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0);
        tbl[6]  = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0);
        tbl[7]  = mk(0, 3'b000, 1, 1, 0,  0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 0);
        tbl[8]  = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 1, 1, 1, 3'b001, 0);
        tbl[9]  = mk(0, 3'b000, 0, 0, 1,  0, 0, 0, 3'b000, 1, 1, 1, 3'b001, 0);
        tbl[10] = mk(0, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0);
        tbl[11] = mk(0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0);

        do_reset("reset");

        // ---- Encode only: 8'b1011_0010, result 3 cycles after the last bit ----
        @(negedge clk);
        enc_req_valid = 1; enc_req_data = 8'b1011_0010;
        #1;
        chk("enc.accept_ready", enc_req_ready, 1);
        chk("enc.dec_ready", dec_req_ready, 0);
        chk("enc.idle_busy", busy, 0);
        for (int b = 0; b < BLOCK_LEN; b++) begin
            @(negedge clk);
            enc_req_valid = 0;
            #1;
            chk($sformatf("enc.start[%0d]", b), codec_start, 1);
            chk($sformatf("enc.mode[%0d]", b), codec_mode, 1);
            chk($sformatf("enc.bit[%0d]", b), codec_data, exp_bits[b]);
        end
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            codec_valid = (w == 3); codec_enc = 3'b101;
            #1;
            chk($sformatf("enc.wait_start[%0d]", w), codec_start, 0);
            chk($sformatf("enc.wait_rv[%0d]", w), rsp_valid, 0);
        end
        @(negedge clk);
        codec_valid = 0; rsp_ready = 1;
        #1;
        chk("enc.rsp_valid", rsp_valid, 1);
        chk("enc.rsp_src", rsp_src, 0);
        chk("enc.rsp_data", rsp_data, 5);
        chk("enc.rsp_timeout", rsp_timeout, 0);
        @(negedge clk);
        rsp_ready = 0;
        #1;
        chk("enc.after_rv", rsp_valid, 0);
        chk("enc.after_busy", busy, 0);
        chk("enc.mode_retained", codec_mode, 1);

        // ---- Decode only, table driven ----
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dec_req_valid = tbl[i].dec_v; dec_req_sym = tbl[i].dec_sym;
            codec_valid = tbl[i].cv; codec_dec = tbl[i].cdec; rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("dec[%0d].enc_ready", i), enc_req_ready, 0);
            chk($sformatf("dec[%0d].dec_ready", i), dec_req_ready, tbl[i].e_dec_rdy);
            chk($sformatf("dec[%0d].start", i), codec_start, tbl[i].e_start);
            chk($sformatf("dec[%0d].mode", i), codec_mode, tbl[i].e_mode);
            chk($sformatf("dec[%0d].sym", i), codec_sym, tbl[i].e_sym);
            chk($sformatf("dec[%0d].data", i), codec_data, 0);
            chk($sformatf("dec[%0d].busy", i), busy, tbl[i].e_busy);
            chk($sformatf("dec[%0d].rsp_valid", i), rsp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                chk($sformatf("dec[%0d].rsp_src", i), rsp_src, tbl[i].e_src);
                chk($sformatf("dec[%0d].rsp_data", i), rsp_data, tbl[i].e_data);
                chk($sformatf("dec[%0d].rsp_timeout", i), rsp_timeout, tbl[i].e_to);
            end
        end
        codec_valid = 0; rsp_ready = 0;

        // ---- Timeout: codec silent, response TIMEOUT cycles after entering WAIT ----
        @(negedge clk);
        dec_req_valid = 1; dec_req_sym = 3'b110;
        #1;
        chk("to.accept", dec_req_ready, 1);
        k = 0; got = 0;
        while (k < 200 && got == 0) begin
            @(negedge clk);
            k++; dec_req_valid = 0;
            #1;
            if (rsp_valid) got = 1;
        end
        chk("to.latency", k, 2 + TIMEOUT);
        chk("to.rsp_timeout", rsp_timeout, 1);
        chk("to.rsp_data", rsp_data, 0);
        chk("to.rsp_src", rsp_src, 1);
        @(negedge clk); rsp_ready = 1;
        @(negedge clk); rsp_ready = 0;
        #1;
        chk("to.idle", busy, 0);

        // ---- Result on the expiry cycle beats the timeout ----
        @(negedge clk);
        dec_req_valid = 1; dec_req_sym = 3'b100; codec_dec = 1;
        #1;
        chk("tie.accept", dec_req_ready, 1);
        k = 0; got = 0;
        while (k < 200 && got == 0) begin
            @(negedge clk);
            k++; dec_req_valid = 0; codec_valid = (k == TIMEOUT + 1);
            #1;
            if (rsp_valid) got = 1;
        end
        codec_valid = 0;
        chk("tie.latency", k, 2 + TIMEOUT);
        chk("tie.rsp_timeout", rsp_timeout, 0);
        chk("tie.rsp_data", rsp_data, 1);
        @(negedge clk); rsp_ready = 1;
        @(negedge clk); rsp_ready = 0;

        // ---- Backpressure: response held 10 cycles with a decode request waiting ----
        @(negedge clk);
        enc_req_valid = 1; enc_req_data = 8'h3C;
        codec_valid = 1; codec_enc = 3'b011; codec_dec = 1;
        #1;
        chk("bp.accept", enc_req_ready, 1);
        k = 0; got = 0;
        while (k < 50 && got == 0) begin
            @(negedge clk);
            k++; enc_req_valid = 0; dec_req_valid = 1; dec_req_sym = 3'b101;
            #1;
            chk($sformatf("bp.busy_ready[%0d]", k), dec_req_ready, 0);
            if (rsp_valid) got = 1;
        end
        chk("bp.latency", k, BLOCK_LEN + 2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            codec_enc = 3'b111;
            #1;
            chk($sformatf("bp.hold_rv[%0d]", c), rsp_valid, 1);
            chk($sformatf("bp.hold_src[%0d]", c), rsp_src, 0);
            chk($sformatf("bp.hold_data[%0d]", c), rsp_data, 3);
            chk($sformatf("bp.hold_to[%0d]", c), rsp_timeout, 0);
            chk($sformatf("bp.hold_ready[%0d]", c), dec_req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1;
        #1;
        chk("bp.hs_rv", rsp_valid, 1);
        chk("bp.hs_ready", dec_req_ready, 0);
        @(negedge clk);
        rsp_ready = 0;
        #1;
        chk("bp.post_rv", rsp_valid, 0);
        chk("bp.post_accept", dec_req_ready, 1);
        k = 0; got = 0;
        while (k < 50 && got == 0) begin
            @(negedge clk);
            k++; dec_req_valid = 0;
            #1;
            if (rsp_valid) got = 1;
        end
        chk("bp.dec_latency", k, 3);
        chk("bp.dec_src", rsp_src, 1);
        chk("bp.dec_data", rsp_data, 1);
        @(negedge clk); rsp_ready = 1; codec_valid = 0;
        @(negedge clk); rsp_ready = 0;

        // ---- Both requesters always valid: enc, dec, enc, dec after reset ----
        enc_req_valid = 1; enc_req_data = 8'h5A;
        dec_req_valid = 1; dec_req_sym = 3'b001;
        codec_valid = 1; codec_enc = 3'b110; codec_dec = 0;
        do_reset("rr_reset");
        rsp_ready = 1;
        for (int j = 0; j < 4; j++) begin
            k = 0; side = 2;
            while (k < 50 && side == 2) begin
                @(negedge clk);
                #1;
                k++;
                chk($sformatf("rr[%0d].both_ready", j), int'(enc_req_ready && dec_req_ready), 0);
                if (enc_req_ready) side = 0;
                else if (dec_req_ready) side = 1;
            end
            chk($sformatf("rr[%0d].grant", j), side, j % 2);
            k = 0; got = 0;
            while (k < 50 && got == 0) begin
                @(negedge clk);
                #1;
                k++;
                if (rsp_valid) got = 1;
            end
            chk($sformatf("rr[%0d].rsp_src", j), rsp_src, j % 2);
            chk($sformatf("rr[%0d].rsp_data", j), rsp_data, (j % 2) ? 0 : 6);
        end
        enc_req_valid = 0; dec_req_valid = 0; codec_valid = 0;
        @(negedge clk);
        rsp_ready = 0;

        // ---- Reset in the middle of ENC_FEED (bit 4 on the wire) ----
        @(negedge clk);
        enc_req_valid = 1; enc_req_data = 8'hFF;
        #1;
        chk("mid.accept", enc_req_ready, 1);
        for (int b = 0; b <= 4; b++) begin
            @(negedge clk);
            enc_req_valid = 0;
            #1;
            chk($sformatf("mid.bit[%0d]", b), codec_data, 1);
        end
        enc_req_valid = 1; dec_req_valid = 1; codec_valid = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("mid.tie_enc_ready", enc_req_ready, 1);
        chk("mid.tie_dec_ready", dec_req_ready, 0);
        enc_req_valid = 0; dec_req_valid = 0;
        rv_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid || busy) rv_seen++;
        end
        chk("mid.no_response", rv_seen, 0);
        codec_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
